// File: rtl/frame_strobe_sequencer.sv
// Frame strobe sequencer: accepts one frame write, presents data, pulses one strobe line, then signals done.
// Optional strobe counter on frames_written is enabled by defining FRAME_SEQ_COUNT_EN.
module frame_strobe_sequencer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int FrameIdxWidth   = 5
) (
    input  logic                       UserCLK,
    input  logic                       resetn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [FrameIdxWidth-1:0]   cmd_frame,
    input  logic [FrameBitsPerRow-1:0] cmd_data,
    input  logic                       cfg_lock,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       done,
    output logic                       err,
    output logic [15:0]                frames_written
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

    localparam logic [FrameIdxWidth:0] MaxIdx = (FrameIdxWidth+1)'(MaxFramesPerCol);

    state_e                     state_q, state_d;
    logic [FrameBitsPerRow-1:0] data_q, data_d;
    logic [FrameIdxWidth-1:0]   idx_q, idx_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       accept;

    assign cmd_ready = (state_q == IDLE) && !cfg_lock;
    assign accept    = cmd_valid && cmd_ready;

    // Strobe and done are registered on the transition into STROBE/HOLD so they align with those states.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        idx_d    = idx_q;
        strobe_d = '0;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ({1'b0, cmd_frame} < MaxIdx) begin
                        data_d  = cmd_data;
                        idx_d   = cmd_frame;
                        state_d = SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                for (int i = 0; i < MaxFramesPerCol; i++)
                    strobe_d[i] = (idx_q == FrameIdxWidth'(i));
            end
            STROBE: begin
                state_d = HOLD;
                done_d  = 1'b1;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            data_q   <= '0;
            idx_q    <= '0;
            strobe_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign done        = done_q;
    assign err         = err_q;

`ifdef FRAME_SEQ_COUNT_EN
    logic [15:0] cnt_q;

    // Counts on the SETUP->STROBE edge so the new value is visible alongside the strobe; saturates.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else if (state_q == SETUP && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    assign frames_written = cnt_q;
`else
    assign frames_written = 16'd0;
`endif

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Self-checking bench for frame_strobe_sequencer: event-scheduled reference model plus directed literal checks.
module tb_frame_strobe_sequencer;

    logic        UserCLK = 1'b0;
    logic        resetn  = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_frame = '0;
    logic [31:0] cmd_data  = '0;
    logic        cfg_lock  = 1'b0;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        done;
    logic        err;
    logic [15:0] frames_written;

    frame_strobe_sequencer #(.MaxFramesPerCol(20), .FrameBitsPerRow(32), .FrameIdxWidth(5)) dut (
        .UserCLK(UserCLK), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_frame(cmd_frame), .cmd_data(cmd_data), .cfg_lock(cfg_lock), .FrameData(FrameData),
        .FrameStrobe(FrameStrobe), .done(done), .err(err), .frames_written(frames_written)
    );

    always #5 UserCLK = ~UserCLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted command schedules its strobe, done and next-ready edge by edge number.
    int          cyc         = 0;
    int          strobe_edge = -10;
    int          done_edge   = -10;
    int          free_edge   = 0;
    logic [4:0]  m_idx       = '0;
    logic [31:0] m_data      = '0;
    logic        m_err       = 1'b0;
    int          m_strobes   = 0;
    int          cnt_base    = 0;
    int          cnt_base_at = 0;
    logic        chk_en      = 1'b0;

    always @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            strobe_edge <= -10;
            done_edge   <= -10;
            free_edge   <= 0;
            m_idx       <= '0;
            m_data      <= '0;
            m_err       <= 1'b0;
            m_strobes   <= 0;
        end else begin
            cyc <= cyc + 1;
            if (cyc + 1 == strobe_edge) m_strobes <= m_strobes + 1;
            if (cmd_valid && cyc >= free_edge && !cfg_lock) begin
                if (cmd_frame < 5'd20) begin
                    m_data      <= cmd_data;
                    m_idx       <= cmd_frame;
                    strobe_edge <= cyc + 2;
                    done_edge   <= cyc + 3;
                    free_edge   <= cyc + 4;
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    function automatic logic [15:0] exp_count();
`ifdef FRAME_SEQ_COUNT_EN
        int v = cnt_base + (m_strobes - cnt_base_at);
        return (v > 65535) ? 16'hFFFF : 16'(v);
`else
        return 16'd0;
`endif
    endfunction

    always @(negedge UserCLK) begin
        if (chk_en) begin
            check("strobe", 64'(FrameStrobe), (resetn && cyc == strobe_edge) ? 64'(20'd1 << m_idx) : 64'd0);
            check("done", 64'(done), 64'(resetn && cyc == done_edge));
            check("data", 64'(FrameData), 64'(m_data));
            check("err", 64'(err), 64'(m_err));
            check("ready", 64'(cmd_ready), 64'((!resetn || cyc >= free_edge) && !cfg_lock));
            check("onehot", 64'($countones(FrameStrobe) <= 1), 64'd1);
            check("count", 64'(frames_written), 64'(exp_count()));
        end
    end

    task automatic drv(input logic v, input logic [4:0] f, input logic [31:0] d, input logic l);
        @(posedge UserCLK);
        #1;
        cmd_valid = v;
        cmd_frame = f;
        cmd_data  = d;
        cfg_lock  = l;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge UserCLK);
        while (!cmd_ready && n < 10) begin
            @(negedge UserCLK);
            n++;
        end
        check(name, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #2;
        check("rst_strobe", 64'(FrameStrobe), 64'd0);
        check("rst_data", 64'(FrameData), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cnt", 64'(frames_written), 64'd0);
        #20;
        resetn = 1'b1;
        chk_en = 1'b1;

        // single write of frame 3
        drv(1'b1, 5'd3, 32'hA5A5_0F0F, 1'b0);
        drv(1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge UserCLK); check("t1_data", 64'(FrameData), 64'hA5A5_0F0F);
        @(negedge UserCLK); check("t1_strobe", 64'(FrameStrobe), 64'h0_0008);
        @(negedge UserCLK); check("t1_done", 64'(done), 64'd1);
        @(negedge UserCLK); check("t1_ready", 64'(cmd_ready), 64'd1);

        // frames 0..19 with valid held high
        for (int f = 0; f < 20; f++) begin
            cmd_valid = 1'b1;
            cmd_frame = 5'(f);
            cmd_data  = 32'h1000_0000 + 32'(f);
            wait_ready("b2b_ready");
            @(posedge UserCLK);
            #1;
        end
        cmd_valid = 1'b0;
        wait_ready("b2b_idle");
`ifdef FRAME_SEQ_COUNT_EN
        check("b2b_count", 64'(frames_written), 64'd21);
`else
        check("b2b_count", 64'(frames_written), 64'd0);
`endif

        // out-of-range frames then a valid one
        drv(1'b1, 5'd20, 32'hDEAD_0020, 1'b0);
        drv(1'b1, 5'd31, 32'hDEAD_0031, 1'b0);
        drv(1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge UserCLK); check("bad_err", 64'(err), 64'd1);
        check("bad_data", 64'(FrameData), 64'h1000_0013);
        drv(1'b1, 5'd5, 32'h0000_0555, 1'b0);
        drv(1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge UserCLK);
        @(negedge UserCLK); check("f5_strobe", 64'(FrameStrobe), 64'h0_0020);
        check("f5_err", 64'(err), 64'd1);
        wait_ready("f5_idle");

        // lock held with valid
        for (int i = 0; i < 10; i++) drv(1'b1, 5'd2, 32'h2222_2222, 1'b1);
        check("lock_ready", 64'(cmd_ready), 64'd0);
        drv(1'b0, 5'd0, 32'h0, 1'b0);

        // lock raised during SETUP of frame 9
        drv(1'b1, 5'd9, 32'h9999_9999, 1'b0);
        drv(1'b1, 5'd9, 32'h9999_9999, 1'b1);
        @(negedge UserCLK);
        @(negedge UserCLK); check("lk_strobe", 64'(FrameStrobe), 64'h0_0200);
        @(negedge UserCLK); check("lk_done", 64'(done), 64'd1);
        drv(1'b0, 5'd0, 32'h0, 1'b0);
        wait_ready("lk_idle");

        // reset during SETUP of frame 7
        drv(1'b1, 5'd7, 32'h7777_7777, 1'b0);
        drv(1'b0, 5'd0, 32'h0, 1'b0);
        #2;
        resetn      = 1'b0;
        cnt_base    = 0;
        cnt_base_at = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge UserCLK);
            check("rs_strobe", 64'(FrameStrobe), 64'd0);
            check("rs_done", 64'(done), 64'd0);
        end
        check("rs_data", 64'(FrameData), 64'd0);
        check("rs_err", 64'(err), 64'd0);
        drv(1'b0, 5'd0, 32'h0, 1'b0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge UserCLK);
            check("rs_nostrobe", 64'(FrameStrobe), 64'd0);
            check("rs_nodone", 64'(done), 64'd0);
        end

`ifdef FRAME_SEQ_COUNT_EN
        @(posedge UserCLK);
        #2;
        force dut.cnt_q = 16'hFFFE;
        cnt_base    = 16'hFFFE;
        cnt_base_at = m_strobes;
        #1;
        release dut.cnt_q;
`endif
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 5'(k + 10), 32'hC0DE_0000 + 32'(k), 1'b0);
            drv(1'b0, 5'd0, 32'h0, 1'b0);
            wait_ready("sat_idle");
        end
`ifdef FRAME_SEQ_COUNT_EN
        check("sat_count", 64'(frames_written), 64'hFFFF);
`else
        check("sat_count", 64'(frames_written), 64'd0);
`endif
        repeat (3) @(negedge UserCLK);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
